// File: rtl/multicycle_controller.sv
// Multicycle control unit for the 8-bit accumulator CPU: one FSM state per cycle,
// with every datapath strobe and mux select decoded from the current state and IR.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [2:0] czn,
    output logic       pcInc,
    output logic       pcLoadEn,
    output logic       PcOrTR,
    output logic       memoryReadEn,
    output logic       memoryWriteEn,
    output logic       irWriteEn,
    output logic       trWriteEn,
    output logic       diLoadEn,
    output logic       regOrMem,
    output logic       aRegWriteEn,
    output logic       bRegWriteEn,
    output logic       RegAOr0,
    output logic       RegBOr0,
    output logic [1:0] aluOpControl,
    output logic       aluResWriteEn,
    output logic       ldCZN,
    output logic       accumulatorWriteEn,
    output logic [1:0] accAddressSel,
    output logic       instrStart
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_ST_B   = 4'd4,
        S_REG_A  = 4'd5,
        S_REG_B  = 4'd6,
        S_EXEC   = 4'd7,
        S_WB     = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [2:0] OP_LDM  = 3'b000;
    localparam logic [2:0] OP_STM  = 3'b001;
    localparam logic [2:0] OP_ADDM = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_JC   = 3'b101;

    state_t     state;
    logic [2:0] op;
    logic       is_reg;
    logic       unused_flags;

    assign op           = ir[7:5];
    assign is_reg       = (ir[7:6] == 2'b11);
    // N is carried on the flag bus but no branch tests it
    assign unused_flags = czn[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= is_reg ? S_REG_A : S_ADDR;
                S_ADDR: begin
                    case (op)
                        OP_LDM, OP_ADDM: state <= S_MEM_RD;
                        OP_STM:          state <= S_ST_B;
                        OP_JMP:          state <= S_JUMP;
                        OP_JZ:           state <= czn[1] ? S_JUMP : S_FETCH;
                        OP_JC:           state <= czn[0] ? S_JUMP : S_FETCH;
                        default:         state <= S_FETCH;
                    endcase
                end
                S_MEM_RD: state <= S_EXEC;
                S_ST_B:   state <= S_EXEC;
                S_REG_A:  state <= S_REG_B;
                S_REG_B:  state <= S_EXEC;
                S_EXEC:   state <= S_WB;
                S_WB:     state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so an aborted instruction emits nothing further.
    always_comb begin
        pcInc              = 1'b0;
        pcLoadEn           = 1'b0;
        PcOrTR             = 1'b0;
        memoryReadEn       = 1'b0;
        memoryWriteEn      = 1'b0;
        irWriteEn          = 1'b0;
        trWriteEn          = 1'b0;
        diLoadEn           = 1'b0;
        regOrMem           = 1'b0;
        aRegWriteEn        = 1'b0;
        bRegWriteEn        = 1'b0;
        RegAOr0            = 1'b0;
        RegBOr0            = 1'b0;
        aluOpControl       = 2'b00;
        aluResWriteEn      = 1'b0;
        ldCZN              = 1'b0;
        accumulatorWriteEn = 1'b0;
        accAddressSel      = 2'b00;
        instrStart         = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    PcOrTR       = 1'b1;
                    memoryReadEn = 1'b1;
                    irWriteEn    = 1'b1;
                    pcInc        = 1'b1;
                    instrStart   = 1'b1;
                end
                S_DECODE: diLoadEn = 1'b1;
                S_ADDR: begin
                    PcOrTR       = 1'b1;
                    memoryReadEn = 1'b1;
                    trWriteEn    = 1'b1;
                    pcInc        = 1'b1;
                end
                S_MEM_RD: begin
                    memoryReadEn = 1'b1;
                    bRegWriteEn  = 1'b1;
                    aRegWriteEn  = (op == OP_ADDM);
                end
                S_ST_B: begin
                    regOrMem    = 1'b1;
                    bRegWriteEn = 1'b1;
                end
                S_REG_A: begin
                    accAddressSel = 2'b10;
                    aRegWriteEn   = 1'b1;
                end
                S_REG_B: begin
                    accAddressSel = 2'b01;
                    regOrMem      = 1'b1;
                    bRegWriteEn   = 1'b1;
                end
                S_EXEC: begin
                    aluResWriteEn = 1'b1;
                    if (is_reg) begin
                        aluOpControl = ir[5:4];
                        ldCZN        = 1'b1;
                    end else if (op == OP_ADDM) begin
                        ldCZN = 1'b1;
                    end else begin
                        // LDM/STM pass B through as 0 + B
                        RegAOr0 = 1'b1;
                    end
                end
                S_WB: begin
                    if (!is_reg && op == OP_STM) begin
                        memoryWriteEn = 1'b1;
                    end else begin
                        accumulatorWriteEn = 1'b1;
                        accAddressSel      = is_reg ? 2'b10 : 2'b00;
                    end
                end
                S_JUMP:  pcLoadEn = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style multicycle control unit for the 8-bit accumulator CPU. It consumes the instruction byte and CZN flags produced by the datapath and drives every datapath control strobe and mux select, one state per cycle. It defines instruction fetch, decode, memory-reference execution, register-register ALU operations and (conditional) jumps.

## Interface
Parameters: none.
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- ir  in  8  instruction register contents; IR[7:5] opcode, IR[4:0] operand field
- czn  in  3  flags: [0]=C, [1]=Z, [2]=N
- pcInc, pcLoadEn  out  1  PC increment / PC load from TR
- PcOrTR  out  1  memory address select: 1=PC, 0=TR
- memoryReadEn, memoryWriteEn  out  1  memory strobes
- irWriteEn, trWriteEn, diLoadEn  out  1  IR / TR / DI load
- regOrMem  out  1  B-register source: 0=memory data, 1=accumulator
- aRegWriteEn, bRegWriteEn  out  1  A / B register load
- RegAOr0, RegBOr0  out  1  ALU operand select: 0=register, 1=zero
- aluOpControl  out  2  00 ADD, 01 ADC, 10 AND, 11 NOT(B)
- aluResWriteEn, ldCZN  out  1  ALU result register load / flag register load
- accumulatorWriteEn  out  1  accumulator file write
- accAddressSel  out  2  accumulator index: 00=DI[4:3], 01=IR[1:0] (rs), 10=IR[3:2] (rd)
- instrStart  out  1  high during the FETCH cycle (verification aid)

## Operation
- Memory class, 2 bytes: byte0 = {op, addr[12:8]}, byte1 = addr[7:0]; register index = DI[4:3].
  - 000 LDM: acc ← mem[addr]. 001 STM: mem[addr] ← acc. 010 ADDM: acc ← acc + mem, flags updated.
  - 011 JMP: PC ← addr. 100 JZ: jump if Z. 101 JC: jump if C.
- Register class, 1 byte: op = 11f, with ALU code {IR[5],IR[4]}; acc[rd] ← acc[rd] op acc[rs]; flags updated.
- States and asserted outputs (all unlisted outputs are 0):
  - FETCH: PcOrTR=1, memoryReadEn, irWriteEn, pcInc, instrStart. Next state DECODE.
  - DECODE: diLoadEn. Next state REG_A if IR[7:6]=11, else ADDR.
  - ADDR: PcOrTR=1, memoryReadEn, trWriteEn, pcInc. Next state by opcode:
    - 000/010 → MEM_RD; 001 → ST_B; 011 → JUMP.
    - 100 → JUMP if czn[1] else FETCH; 101 → JUMP if czn[0] else FETCH.
  - MEM_RD: PcOrTR=0, memoryReadEn, regOrMem=0, bRegWriteEn. For ADDM only, also aRegWriteEn with accAddressSel=00. Next state EXEC.
  - ST_B: accAddressSel=00, regOrMem=1, bRegWriteEn. Next state EXEC.
  - REG_A: accAddressSel=10, aRegWriteEn. Next state REG_B.
  - REG_B: accAddressSel=01, regOrMem=1, bRegWriteEn. Next state EXEC.
  - EXEC: RegBOr0=0, aluResWriteEn.
    - LDM/STM: RegAOr0=1, aluOpControl=00.
    - ADDM: RegAOr0=0, aluOpControl=00, ldCZN.
    - Register class: RegAOr0=0, aluOpControl={IR[5],IR[4]}, ldCZN.
    - Next state WB.
  - WB: LDM/ADDM: accumulatorWriteEn, accAddressSel=00. STM: memoryWriteEn, PcOrTR=0. Register class: accumulatorWriteEn, accAddressSel=10. Next state FETCH.
  - JUMP: pcLoadEn. Next state FETCH.
- Opcode decisions use ir sampled in the current cycle. IR is written only in FETCH, so ir is stable from DECODE until the next FETCH.
- The conditional-jump decision samples czn in the ADDR cycle.

## Timing
- Outputs are a pure decode of state, combinational with no registered delay. All outputs are forced to 0 while rst is high.
- Asynchronous reset puts state in FETCH immediately. The first FETCH strobes appear in the cycle after rst deasserts.
- Reset mid-instruction aborts it with no further strobes; any partial datapath writes are not undone.
- Cycles per instruction: register class 6; LDM/STM/ADDM 6; JMP and taken JZ/JC 4; untaken JZ/JC 3.
- Exactly one memory strobe per cycle at most; memoryReadEn and memoryWriteEn are never high together.
- pcInc and pcLoadEn are never high together.
- Undefined state encodings return to FETCH on the next clock.

## Test plan
- Reset: hold rst high for 3 cycles → all outputs 0. After release, instrStart=1 with pcInc=1, irWriteEn=1 and memoryReadEn=1 in the first cycle.
- ir=8'hC6 (ADD rd=1, rs=2) → states FETCH, DECODE, REG_A, REG_B, EXEC, WB.
  - REG_A: accAddressSel=10. REG_B: accAddressSel=01. EXEC: aluOpControl=00, ldCZN=1. WB: accumulatorWriteEn=1.
  - instrStart reasserts on cycle 7.
- ir=8'h25 (STM) → ADDR has trWriteEn=1 and pcInc=1; ST_B has regOrMem=1. WB has memoryWriteEn=1 with PcOrTR=0 and accumulatorWriteEn=0.
- ir=8'h80 (JZ): with czn=3'b010 → pcLoadEn=1 in cycle 4 and FETCH in cycle 5. With czn=3'b000 → no pcLoadEn, FETCH in cycle 4.
- ir=8'h40 (ADDM) → MEM_RD has bRegWriteEn=1 and aRegWriteEn=1. EXEC has RegAOr0=0 and ldCZN=1.
- Assert rst during the EXEC cycle of ADDM → outputs go to 0 immediately, no WB strobe follows, and the next cycle after release is FETCH.
